// File: rtl/cursor_pkg.sv
// Shared cursor-path definitions: report layout, button bits, packer FSM states.
// Optional build macro used by hid_report_packer: HID_IDLE_SUPPRESS_EN.
package cursor_pkg;

   localparam int REPORT_LEN = 4;

   localparam logic [1:0] IDX_BTN   = 2'd0;
   localparam logic [1:0] IDX_X     = 2'd1;
   localparam logic [1:0] IDX_Y     = 2'd2;
   localparam logic [1:0] IDX_WHEEL = 2'd3;

   localparam int BTN_L = 0;
   localparam int BTN_R = 1;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage

// File: rtl/hid_report_packer_if.sv
// Valid/ready byte stream carrying HID reports toward the transport.
interface hid_report_packer_if;

   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       last;

   modport master (
      output data,
      output valid,
      output last,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      input  last,
      output ready
   );

endinterface

// File: rtl/hid_report_packer_sat_accum.sv
// Per-axis saturating motion accumulator with snapshot-clear.
module sat_accum #(
   parameter int ACC_W   = 10,
   parameter int SAT_MAX = 127
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic signed [7:0] add,
   input  logic              clr,
   output logic signed [7:0] sat_byte
);

   localparam logic signed [ACC_W:0] HI =
      (ACC_W+1)'(SAT_MAX);
   localparam logic signed [ACC_W:0] LO = -HI;
   localparam logic signed [ACC_W-1:0] HI_S =
      ACC_W'(SAT_MAX);
   localparam logic signed [ACC_W-1:0] LO_S = -HI_S;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W:0]   raw;
   logic signed [ACC_W-1:0] sum;

   // One extra bit keeps acc + add exact before clamping.
   always_comb begin
      raw = {acc[ACC_W-1], acc}
          + {{(ACC_W-7){add[7]}}, add};
      if (raw > HI)
         sum = HI_S;
      else if (raw < LO)
         sum = LO_S;
      else
         sum = raw[ACC_W-1:0];
   end

   assign sat_byte = sum[7:0];

   always_ff @(posedge clk) begin
      if (!rst_n)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else
         acc <= sum;
   end

endmodule

// File: rtl/hid_report_packer.sv
// Accumulates motion/buttons and streams a 4-byte boot-mouse report per tick.
// Build option HID_IDLE_SUPPRESS_EN: skip reports with no motion and no button change.
module hid_report_packer
   import cursor_pkg::*;
#(
   parameter int ACC_W   = 10,
   parameter int SAT_MAX = 127
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_tick,
   input  logic signed [7:0]   dx,
   input  logic signed [7:0]   dy,
   input  logic                left_btn,
   input  logic                right_btn,
   hid_report_packer_if.master m,
   output logic                busy,
   output logic                overrun
);

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  idx;
   logic [1:0]  idx_nxt;
   logic        pending;
   logic        pend_nxt;
   logic        ovr_nxt;
   logic        trig;
   logic        send;
   logic        quiet;
   logic        hs;
   logic        valid;
   logic        btn_l;
   logic        btn_r;
   logic [7:0]  snap_b;
   logic [7:0]  rep_b;
   logic [7:0]  rep_x;
   logic [7:0]  rep_y;
   logic [7:0]  data_mux;
   logic signed [7:0] x_byte;
   logic signed [7:0] y_byte;

   sat_accum #(
      .ACC_W   (ACC_W),
      .SAT_MAX (SAT_MAX)
   ) u_acc_x (
      .clk      (clk),
      .rst_n    (rst_n),
      .add      (dx),
      .clr      (trig),
      .sat_byte (x_byte)
   );

   sat_accum #(
      .ACC_W   (ACC_W),
      .SAT_MAX (SAT_MAX)
   ) u_acc_y (
      .clk      (clk),
      .rst_n    (rst_n),
      .add      (dy),
      .clr      (trig),
      .sat_byte (y_byte)
   );

   always_comb begin
      snap_b        = '0;
      snap_b[BTN_L] = btn_l | left_btn;
      snap_b[BTN_R] = btn_r | right_btn;
   end

`ifdef HID_IDLE_SUPPRESS_EN
   logic [7:0] last_b;

   assign quiet = (x_byte == 8'sd0)
               && (y_byte == 8'sd0)
               && (snap_b == last_b);

   always_ff @(posedge clk) begin
      if (!rst_n)
         last_b <= '0;
      else if (send)
         last_b <= snap_b;
   end
`else
   assign quiet = 1'b0;
`endif

   assign valid = (state == SEND);
   assign hs    = valid & m.ready;
   assign send  = trig & ~quiet;
   assign busy  = valid;

   // A trigger is a tick in IDLE, or the final handshake with a tick owed.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      pend_nxt  = pending;
      ovr_nxt   = 1'b0;
      trig      = 1'b0;
      unique case (state)
         IDLE: trig = frame_tick;
         SEND: begin
            if (hs)
               idx_nxt = idx + 2'd1;
            if (hs && (idx == IDX_WHEEL)) begin
               trig      = pending | frame_tick;
               ovr_nxt   = pending & frame_tick;
               pend_nxt  = 1'b0;
               state_nxt = IDLE;
            end else if (frame_tick) begin
               if (pending)
                  ovr_nxt = 1'b1;
               else
                  pend_nxt = 1'b1;
            end
         end
      endcase
      if (trig && !quiet) begin
         state_nxt = SEND;
         idx_nxt   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         pending <= pend_nxt;
         overrun <= ovr_nxt;
      end
   end

   // Snapshot consumes the sticky bits; current levels are not re-latched.
   always_ff @(posedge clk) begin
      if (!rst_n || trig) begin
         btn_l <= 1'b0;
         btn_r <= 1'b0;
      end else begin
         btn_l <= btn_l | left_btn;
         btn_r <= btn_r | right_btn;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rep_b <= '0;
         rep_x <= '0;
         rep_y <= '0;
      end else if (send) begin
         rep_b <= snap_b;
         rep_x <= x_byte;
         rep_y <= y_byte;
      end
   end

   always_comb begin
      data_mux = 8'h00;
      if (valid) begin
         unique case (idx)
            IDX_BTN:   data_mux = rep_b;
            IDX_X:     data_mux = rep_x;
            IDX_Y:     data_mux = rep_y;
            IDX_WHEEL: data_mux = 8'h00;
         endcase
      end
   end

   assign m.data  = data_mux;
   assign m.valid = valid;
   assign m.last  = valid && (idx == IDX_WHEEL);

endmodule

// File: tb/tb_hid_report_packer.sv
// Self-checking bench for hid_report_packer: directed scenarios plus random
// traffic, all checked against a report-level reference model.
module tb_hid_report_packer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic [7:0] dx = 8'h00;
   logic [7:0] dy = 8'h00;
   logic       left_btn = 1'b0;
   logic       right_btn = 1'b0;
   logic       busy;
   logic       overrun;

   hid_report_packer_if m();

   hid_report_packer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .dx         (dx),
      .dy         (dy),
      .left_btn   (left_btn),
      .right_btn  (right_btn),
      .m          (m),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   // Reference model: report-level view of accumulation and delivery.
   int         ax = 0;
   int         ay = 0;
   bit         bl = 0;
   bit         br = 0;
   bit         snd = 0;
   bit         pend = 0;
   bit         e_ovr = 0;
   int         cnt = 0;
   logic [7:0] cur [4];
   logic [7:0] last_b = 8'h00;
   logic [7:0] rx_q [$];
   int         ovr_seen = 0;

   function automatic int sat(input int v);
      if (v > 127) return 127;
      if (v < -127) return -127;
      return v;
   endfunction

   always @(negedge clk) begin
      byte        sdx;
      byte        sdy;
      int         sx;
      int         sy;
      logic [7:0] b;
      bit         hs;
      bit         done;
      bit         trig;
      bit         ovr;
      bit         quiet;

      chk("valid", m.valid, snd);
      chk("busy", busy, snd);
      chk("overrun", overrun, e_ovr);
      if (snd) begin
         chk("data", m.data, cur[cnt]);
         chk("last", m.last, cnt == 3);
      end else begin
         chk("last_idle", m.last, 0);
      end
      if (m.valid && m.ready)
         rx_q.push_back(m.data);
      if (overrun)
         ovr_seen++;

      if (!rst_n) begin
         ax = 0; ay = 0; bl = 0; br = 0;
         snd = 0; pend = 0; e_ovr = 0; cnt = 0;
         last_b = 8'h00;
      end else begin
         sdx = dx;
         sdy = dy;
         sx = sat(ax + sdx);
         sy = sat(ay + sdy);
         b = {6'b0, right_btn | br, left_btn | bl};
         hs = snd && m.ready;
         done = hs && (cnt == 3);
         trig = 0;
         ovr = 0;
         if (!snd) begin
            trig = frame_tick;
         end else if (done) begin
            trig = pend | frame_tick;
            ovr = pend & frame_tick;
            pend = 0;
         end else if (frame_tick) begin
            if (pend) ovr = 1;
            else pend = 1;
         end
         if (hs) cnt++;
         if (trig) begin
            ax = 0; ay = 0; bl = 0; br = 0;
            quiet = 0;
`ifdef HID_IDLE_SUPPRESS_EN
            quiet = (sx == 0) && (sy == 0) && (b == last_b);
`endif
            if (!quiet) begin
               cur[0] = b;
               cur[1] = sx[7:0];
               cur[2] = sy[7:0];
               cur[3] = 8'h00;
               snd = 1;
               cnt = 0;
               last_b = b;
            end else begin
               snd = 0;
            end
         end else begin
            ax = sx; ay = sy;
            bl = bl | left_btn;
            br = br | right_btn;
            if (done) snd = 0;
         end
         e_ovr = ovr;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         cyc(1);
         n++;
      end
      chk("idle_timeout", busy, 0);
      cyc(1);
   endtask

   task automatic chk_rep(input string tag, input int base,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2);
      if (rx_q.size() < base + 4) begin
         chk({tag, "_len"}, rx_q.size(), base + 4);
      end else begin
         chk({tag, "_b0"}, rx_q[base], b0);
         chk({tag, "_b1"}, rx_q[base+1], b1);
         chk({tag, "_b2"}, rx_q[base+2], b2);
         chk({tag, "_b3"}, rx_q[base+3], 8'h00);
      end
   endtask

   initial begin
      int ov0;
      m.ready = 1'b1;
      cyc(3);
      rst_n = 1'b1;

      // basic report
      rx_q.delete();
      dx = 8'd5;
      dy = 8'hFE;
      cyc(3);
      dx = 8'd0;
      dy = 8'd0;
      tick();
      wait_idle();
      chk("basic_len", rx_q.size(), 4);
      chk_rep("basic", 0, 8'h00, 8'h0F, 8'hFA);

      // saturation, then an empty follow-up
      rx_q.delete();
      dx = 8'd100;
      cyc(4);
      dx = 8'd0;
      tick();
      wait_idle();
      dy = 8'h80;
      cyc(2);
      dy = 8'd0;
      tick();
      wait_idle();
      tick();
      wait_idle();
      chk_rep("sat_x", 0, 8'h00, 8'h7F, 8'h00);
      chk_rep("sat_y", 4, 8'h00, 8'h00, 8'h81);
`ifdef HID_IDLE_SUPPRESS_EN
      chk("sat_zero_len", rx_q.size(), 8);
`else
      chk_rep("sat_zero", 8, 8'h00, 8'h00, 8'h00);
`endif

      // backpressure at byte 1
      rx_q.delete();
      dx = 8'd3;
      cyc(1);
      dx = 8'd0;
      tick();
      cyc(1);
      m.ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk("bp_data", m.data, 8'h03);
         chk("bp_valid", m.valid, 1);
      end
      m.ready = 1'b1;
      wait_idle();
      chk("bp_len", rx_q.size(), 4);
      chk_rep("bp", 0, 8'h00, 8'h03, 8'h00);

      // one tick while busy
      rx_q.delete();
      ov0 = ovr_seen;
      dx = 8'd1;
      m.ready = 1'b0;
      tick();
      cyc(2);
      tick();
      dx = 8'd0;
      m.ready = 1'b1;
      wait_idle();
      chk("busy1_len", rx_q.size(), 8);
      chk("busy1_ovr", ovr_seen - ov0, 0);

      // two ticks while busy
      rx_q.delete();
      ov0 = ovr_seen;
      dy = 8'd2;
      m.ready = 1'b0;
      tick();
      cyc(1);
      tick();
      cyc(1);
      tick();
      dy = 8'd0;
      cyc(2);
      m.ready = 1'b1;
      wait_idle();
      chk("busy2_len", rx_q.size(), 8);
      chk("busy2_ovr", ovr_seen - ov0, 1);

      // button capture
      rx_q.delete();
      left_btn = 1'b1;
      cyc(1);
      left_btn = 1'b0;
      cyc(2);
      tick();
      wait_idle();
      tick();
      wait_idle();
      right_btn = 1'b1;
      cyc(1);
      tick();
      right_btn = 1'b0;
      wait_idle();
      if (rx_q.size() >= 1) chk("btn_l", rx_q[0], 8'h01);
`ifndef HID_IDLE_SUPPRESS_EN
      if (rx_q.size() >= 9) begin
         chk("btn_clr", rx_q[4], 8'h00);
         chk("btn_r", rx_q[8], 8'h02);
      end else begin
         chk("btn_len", rx_q.size(), 12);
      end
`endif

      // reset in the middle of a report
      dx = 8'd7;
      cyc(1);
      dx = 8'd0;
      tick();
      cyc(2);
      rst_n = 1'b0;
      cyc(1);
      chk("rst_valid", m.valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", m.data, 0);
      rst_n = 1'b1;
      rx_q.delete();
      dx = 8'd1;
      cyc(1);
      dx = 8'd0;
      tick();
      wait_idle();
      chk_rep("post_rst", 0, 8'h00, 8'h01, 8'h00);

      // zero-motion tick with unchanged buttons
      rx_q.delete();
      tick();
      cyc(6);
`ifdef HID_IDLE_SUPPRESS_EN
      chk("suppress_len", rx_q.size(), 0);
`else
      wait_idle();
      chk_rep("zero_rep", 0, 8'h00, 8'h00, 8'h00);
`endif

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         dx = 8'($urandom);
         dy = 8'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 4));
         left_btn = ($urandom_range(0, 15) == 0);
         right_btn = ($urandom_range(0, 15) == 0);
         frame_tick = ($urandom_range(0, 9) == 0);
         m.ready = ($urandom_range(0, 9) < 7);
         rst_n = ($urandom_range(0, 599) != 0);
         cyc(1);
      end
      frame_tick = 1'b0;
      rst_n = 1'b1;
      m.ready = 1'b1;
      dx = 8'd0;
      dy = 8'd0;
      left_btn = 1'b0;
      right_btn = 1'b0;
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hid_report_packer.md
Name: hid_report_packer

Overview:
- Downstream stage of the cursor path. Consumes per-cycle signed motion (dx, dy) and the left/right button levels from the click generator.
- Accumulates motion between host report periods with saturation.
- On each frame tick, emits a 4-byte HID boot-mouse report over a valid/ready byte stream to the USB/UART transport.

Parameters:
- ACC_W, 10, internal signed accumulator width per axis (must be >= 9).
- SAT_MAX, 127, magnitude limit for reported dx/dy. Reported range is [-SAT_MAX, +SAT_MAX].

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- frame_tick  in  1  one-cycle pulse per report period
- dx  in  8  signed motion this cycle
- dy  in  8  signed motion this cycle
- left_btn  in  1  left button level
- right_btn  in  1  right button level
- m_data  out  8  report byte
- m_valid  out  1  m_data valid
- m_ready  in  1  sink accepts byte when m_valid && m_ready
- m_last  out  1  high with the final byte (index 3)
- busy  out  1  report in flight
- overrun  out  1  one-cycle pulse when a tick is dropped

Behaviour:
- Reset (rst_n low at a clk edge):
  - m_valid, m_last, busy, overrun, m_data = 0.
  - Accumulators, sticky buttons, pending flag and byte index are cleared.
  - Applies mid-report: the stream is abandoned with no completion.
- Accumulation, every cycle:
  - acc_x <= sat(acc_x + dx), and likewise for y.
  - sat() clamps to [-SAT_MAX, +SAT_MAX].
  - Input -128 is legal and clamps as a value.
- Sticky buttons:
  - btn_l <= btn_l | left_btn; btn_r <= btn_r | right_btn.
  - A button high for any cycle since the last snapshot is therefore reported.
- Snapshot, taken on an accepted trigger:
  - Latches rep_x = sat(acc_x + dx), rep_y = sat(acc_y + dy).
  - Latches rep_b = {6'b0, btn_r|right_btn, btn_l|left_btn}.
  - In the same cycle: acc <= 0, and sticky <= 0 (current levels are not re-sticky'd).
- FSM states: IDLE, SEND.
  - IDLE: frame_tick -> snapshot, go to SEND, idx = 0. m_valid rises the cycle after the tick (latency 1).
  - SEND: m_data = {rep_b, rep_x, rep_y, 8'h00}[idx] and m_valid = 1.
  - SEND: on handshake, idx++. m_last = (idx == 3).
  - SEND: handshake at idx 3 with pending = 1 -> snapshot in that cycle, clear pending, idx = 0, stay in SEND with no bubble.
  - SEND: handshake at idx 3 with pending = 0 -> go to IDLE, m_valid drops next cycle.
- Tick while in SEND:
  - pending = 0 -> set pending; the accumulator keeps running.
  - pending = 1 -> overrun pulses for 1 cycle; pending stays 1 and nothing is lost except the tick itself.
- Stream rules:
  - m_data and m_last are stable while m_valid && !m_ready.
  - m_valid is never withdrawn before its handshake.
- busy = (state == SEND).

Optional Feature:
- Macro HID_IDLE_SUPPRESS_EN.
- When defined: a trigger whose snapshot has rep_x = 0, rep_y = 0 and rep_b equal to the last transmitted rep_b sends nothing.
  - The snapshot still clears acc and sticky.
  - FSM stays in (or returns to) IDLE.
  - The last transmitted rep_b register resets to 0.
- When undefined: every accepted trigger emits a report, including all-zero reports.

Decomposition:
- Shared package cursor_pkg holds:
  - REPORT_LEN = 4
  - byte index constants IDX_BTN = 0, IDX_X = 1, IDX_Y = 2, IDX_WHEEL = 3
  - button bit positions BTN_L = 0, BTN_R = 1
  - the FSM state typedef
- Sub-module sat_accum: per-axis saturating accumulator with add, clear-and-load (snapshot) and reset. Instantiated twice (x, y).

Test Plan:
- Basic report:
  - dx = +5, dy = -2 for 3 cycles, then 0; tick; m_ready = 1.
  - Expect bytes 00, 0F, FA, 00 on consecutive cycles starting the cycle after the tick, m_last on the 4th, then m_valid = 0.
- Saturation:
  - dx = +100 for 4 cycles, then tick -> byte1 = 7F.
  - dy = -128 for 2 cycles, then tick -> byte2 = 81.
  - The following report has 00 motion.
- Backpressure:
  - m_ready low for 10 cycles while idx = 1.
  - Expect m_data = byte1 held stable and m_valid held high; after release, remaining bytes in order with no duplication.
- Ticks while busy:
  - One tick during SEND -> second report starts the cycle after the first m_last handshake.
  - Two ticks during SEND -> overrun = 1 for exactly one cycle; only one extra report.
- Button capture:
  - left_btn high for 1 cycle between ticks -> next report byte0 = 01.
  - The report after that has byte0 = 00.
  - right_btn held through the tick -> byte0 = 02.
- Reset and suppression:
  - rst_n low at idx = 2 -> next cycle m_valid = 0 and busy = 0; the next tick sends a fresh report from zeroed accumulators.
  - With HID_IDLE_SUPPRESS_EN: a zero-motion tick with unchanged buttons -> m_valid stays 0.
